// File: rtl/shared_mem_arb_ble.sv
// Sequencer/arbiter for the BLE shared-memory FIFO: owns mode/data_size and guards every mode switch.
// Optional watchdog on TX_RUN/RX_RUN enabled by defining SHMEM_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | AHB may load a TX packet, mode=1
// TX_GUARD  | quiet interval before the TX chain starts
// TX_RUN    | BLE TX chain reads the FIFO
// RX_GUARD  | mode=0, quiet interval before the RX chain starts
// RX_RUN    | BLE RX chain writes the FIFO
// RX_DRAIN  | AHB reads the received words out
// RET_GUARD | mode=1, quiet interval before returning to IDLE
module shared_mem_arb_ble #(
    parameter int AD      = 8,
    parameter int GUARD   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic        hclk,
    input  logic        reset,
    input  logic        cfg_start_tx,
    input  logic        cfg_start_rx,
    input  logic [16:0] cfg_len,
    input  logic        ahb_wr_req,
    input  logic        ahb_rd_req,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    input  logic        w_done_flag,
    input  logic        ble_tx_done,
    input  logic        ble_rx_done,
    output logic        mode,
    output logic [16:0] data_size,
    output logic        ahb_wr_grant,
    output logic        ahb_rd_grant,
    output logic        tx_irq,
    output logic        ble_tx_en,
    output logic        ble_rx_en,
    output logic        done_irq,
    output logic        err,
    output logic        busy,
    output logic [2:0]  state,
    output logic [14:0] words_left
);

    localparam int GW = $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_GUARD  = 3'd1,
        TX_RUN    = 3'd2,
        RX_GUARD  = 3'd3,
        RX_RUN    = 3'd4,
        RX_DRAIN  = 3'd5,
        RET_GUARD = 3'd6
    } state_t;

    state_t        cur;
    logic [GW-1:0] guard_cnt;
    logic [17:0]   len_round;
    logic          start_any;
    logic          unused_params;

    // AD only sizes the FIFO outside this block
    assign unused_params = (AD != 0) ^ (TIMEOUT != 0);

    assign len_round    = {1'b0, cfg_len} + 18'd3;
    assign start_any    = cfg_start_tx | cfg_start_rx;
    assign state        = cur;
    assign ahb_wr_grant = (cur == IDLE) && ahb_wr_req && !fifo_full;
    assign ahb_rd_grant = (cur == RX_DRAIN) && ahb_rd_req && !fifo_empty;

`ifdef SHMEM_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_hit;
    assign wd_hit = (wd_cnt == 16'(TIMEOUT - 1));
`endif

    always_ff @(posedge hclk) begin
        if (reset) begin
            cur        <= IDLE;
            mode       <= 1'b1;
            data_size  <= '0;
            words_left <= '0;
            guard_cnt  <= '0;
            tx_irq     <= 1'b0;
            done_irq   <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            ble_tx_en  <= 1'b0;
            ble_rx_en  <= 1'b0;
`ifdef SHMEM_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            tx_irq   <= 1'b0;
            done_irq <= 1'b0;
            err      <= (cur != IDLE) && start_any;
`ifdef SHMEM_ARB_TIMEOUT_EN
            if (cur == TX_RUN || cur == RX_RUN)
                wd_cnt <= wd_cnt + 16'd1;
`endif
            case (cur)
                IDLE: begin
                    if (start_any) begin
                        if (cfg_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            // simultaneous requests: TX wins, collision still flagged
                            err       <= cfg_start_tx & cfg_start_rx;
                            data_size <= cfg_len;
                            guard_cnt <= GUARD_LOAD;
                            busy      <= 1'b1;
                            if (cfg_start_tx) begin
                                cur <= TX_GUARD;
                            end else begin
                                cur        <= RX_GUARD;
                                mode       <= 1'b0;
                                words_left <= len_round[16:2];
                            end
                        end
                    end
                end
                TX_GUARD: begin
                    if (guard_cnt == '0) begin
                        cur       <= TX_RUN;
                        ble_tx_en <= 1'b1;
                        tx_irq    <= 1'b1;
`ifdef SHMEM_ARB_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                TX_RUN: begin
                    if (ble_tx_done || fifo_empty) begin
                        cur       <= IDLE;
                        ble_tx_en <= 1'b0;
                        done_irq  <= 1'b1;
                        busy      <= 1'b0;
                    end
`ifdef SHMEM_ARB_TIMEOUT_EN
                    else if (wd_hit) begin
                        cur       <= IDLE;
                        ble_tx_en <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                    end
`endif
                end
                RX_GUARD: begin
                    if (guard_cnt == '0) begin
                        cur       <= RX_RUN;
                        ble_rx_en <= 1'b1;
`ifdef SHMEM_ARB_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                RX_RUN: begin
                    if (ble_rx_done || w_done_flag) begin
                        cur       <= RX_DRAIN;
                        ble_rx_en <= 1'b0;
                    end
`ifdef SHMEM_ARB_TIMEOUT_EN
                    else if (wd_hit) begin
                        cur       <= RET_GUARD;
                        ble_rx_en <= 1'b0;
                        mode      <= 1'b1;
                        guard_cnt <= GUARD_LOAD;
                        err       <= 1'b1;
                    end
`endif
                end
                RX_DRAIN: begin
                    if (ahb_rd_grant && words_left != '0)
                        words_left <= words_left - 15'd1;
                    if (words_left == '0 || fifo_empty ||
                        (ahb_rd_grant && words_left == 15'd1)) begin
                        cur       <= RET_GUARD;
                        mode      <= 1'b1;
                        guard_cnt <= GUARD_LOAD;
                        done_irq  <= 1'b1;
                    end
                end
                RET_GUARD: begin
                    if (guard_cnt == '0) begin
                        cur  <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                default: begin
                    cur       <= IDLE;
                    mode      <= 1'b1;
                    busy      <= 1'b0;
                    ble_tx_en <= 1'b0;
                    ble_rx_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_mem_arb_ble.sv
// Directed bench for shared_mem_arb_ble with GUARD=4: TX, RX/drain, collisions, flow control, reset.
module tb_shared_mem_arb_ble;

    logic        hclk = 1'b0;
    logic        reset;
    logic        cfg_start_tx, cfg_start_rx;
    logic [16:0] cfg_len;
    logic        ahb_wr_req, ahb_rd_req;
    logic        fifo_full, fifo_empty, w_done_flag;
    logic        ble_tx_done, ble_rx_done;
    logic        mode;
    logic [16:0] data_size;
    logic        ahb_wr_grant, ahb_rd_grant;
    logic        tx_irq, ble_tx_en, ble_rx_en, done_irq, err, busy;
    logic [2:0]  state;
    logic [14:0] words_left;

    int total = 0;
    int bad   = 0;

    shared_mem_arb_ble #(.AD(8), .GUARD(4), .TIMEOUT(100)) dut (
        .hclk(hclk), .reset(reset),
        .cfg_start_tx(cfg_start_tx), .cfg_start_rx(cfg_start_rx), .cfg_len(cfg_len),
        .ahb_wr_req(ahb_wr_req), .ahb_rd_req(ahb_rd_req),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .w_done_flag(w_done_flag),
        .ble_tx_done(ble_tx_done), .ble_rx_done(ble_rx_done),
        .mode(mode), .data_size(data_size),
        .ahb_wr_grant(ahb_wr_grant), .ahb_rd_grant(ahb_rd_grant),
        .tx_irq(tx_irq), .ble_tx_en(ble_tx_en), .ble_rx_en(ble_rx_en),
        .done_irq(done_irq), .err(err), .busy(busy),
        .state(state), .words_left(words_left)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cfg_start_tx = 0; cfg_start_rx = 0; cfg_len = '0;
        ahb_wr_req = 0; ahb_rd_req = 0;
        fifo_full = 0; fifo_empty = 0; w_done_flag = 0;
        ble_tx_done = 0; ble_rx_done = 0;
        step(2);
        check("rst_state", 32'(state), 0);
        check("rst_mode", 32'(mode), 1);
        check("rst_size", 32'(data_size), 0);
        check("rst_words", 32'(words_left), 0);
        check("rst_outs", 32'({busy, err, tx_irq, done_irq, ble_tx_en, ble_rx_en}), 0);
        reset = 1'b0;
        step();
        check("idle_state", 32'(state), 0);

        // TX flow: three granted writes, then start with len 12
        ahb_wr_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("wr_grant", 32'(ahb_wr_grant), 1);
            step();
        end
        fifo_full = 1;
        #1 check("wr_full_nogrant", 32'(ahb_wr_grant), 0);
        fifo_full = 0; ahb_wr_req = 0;
        ahb_rd_req = 1;
        #1 check("rd_idle_nogrant", 32'(ahb_rd_grant), 0);
        ahb_rd_req = 0;

        cfg_len = 17'd12; cfg_start_tx = 1;
        step();
        cfg_start_tx = 0;
        check("txg_state", 32'(state), 1);
        check("txg_busy", 32'(busy), 1);
        check("txg_size", 32'(data_size), 12);
        check("txg_en", 32'({ble_tx_en, tx_irq, err}), 0);
        ahb_wr_req = 1;
        #1 check("txg_wr_nogrant", 32'(ahb_wr_grant), 0);
        ahb_wr_req = 0;
        step(3);
        check("txg_hold", 32'({state, ble_tx_en}), {3'd1, 1'b0});
        step();
        check("txrun_state", 32'(state), 2);
        check("txrun_en_irq", 32'({ble_tx_en, tx_irq}), 2'b11);
        step();
        check("txrun_irq_pulse", 32'({ble_tx_en, tx_irq}), 2'b10);
        cfg_start_rx = 1;
        step();
        cfg_start_rx = 0;
        check("busy_start_err", 32'({state, err}), {3'd2, 1'b1});
        step();
        check("busy_err_pulse", 32'(err), 0);
        ble_tx_done = 1;
        step();
        ble_tx_done = 0;
        check("txdone", 32'({state, ble_tx_en, done_irq, busy}), {3'd0, 1'b0, 1'b1, 1'b0});
        step();
        check("txdone_pulse", 32'(done_irq), 0);

        // RX flow: len 10 -> 3 words
        cfg_len = 17'd10; cfg_start_rx = 1;
        step();
        cfg_start_rx = 0;
        check("rxg_state_mode", 32'({state, mode}), {3'd3, 1'b0});
        check("rxg_words", 32'(words_left), 3);
        check("rxg_size", 32'(data_size), 10);
        check("rxg_en", 32'(ble_rx_en), 0);
        step(3);
        check("rxg_hold", 32'({state, ble_rx_en}), {3'd3, 1'b0});
        step();
        check("rxrun", 32'({state, ble_rx_en, mode}), {3'd4, 1'b1, 1'b0});
        step();
        ble_rx_done = 1;
        step();
        ble_rx_done = 0;
        check("drain_entry", 32'({state, ble_rx_en}), {3'd5, 1'b0});
        ahb_rd_req = 1;
        #1 check("rd_grant1", 32'(ahb_rd_grant), 1);
        step();
        check("words_2", 32'({state, words_left}), {3'd5, 15'd2});
        #1 check("rd_grant2", 32'(ahb_rd_grant), 1);
        step();
        check("words_1", 32'(words_left), 1);
        #1 check("rd_grant3", 32'(ahb_rd_grant), 1);
        step();
        check("ret_entry", 32'({state, mode, done_irq}), {3'd6, 1'b1, 1'b1});
        check("ret_words", 32'(words_left), 0);
        #1 check("ret_nogrant", 32'(ahb_rd_grant), 0);
        ahb_rd_req = 0;
        step(3);
        check("ret_hold", 32'({state, done_irq, busy}), {3'd6, 1'b0, 1'b1});
        step();
        check("ret_idle", 32'({state, busy, mode}), {3'd0, 1'b0, 1'b1});

        // both starts at once: TX path plus err; FIFO empty ends TX
        cfg_len = 17'd8; cfg_start_tx = 1; cfg_start_rx = 1;
        step();
        cfg_start_tx = 0; cfg_start_rx = 0;
        check("coll_state", 32'({state, err, mode}), {3'd1, 1'b1, 1'b1});
        step();
        check("coll_err_pulse", 32'(err), 0);
        step(3);
        check("coll_txrun", 32'(state), 2);
        fifo_empty = 1;
        step();
        fifo_empty = 0;
        check("empty_txend", 32'({state, done_irq}), {3'd0, 1'b1});

        // zero length rejected
        cfg_len = '0; cfg_start_tx = 1;
        step();
        cfg_start_tx = 0;
        check("len0", 32'({state, err, busy}), {3'd0, 1'b1, 1'b0});
        check("len0_size", 32'(data_size), 8);

        // RX drain exits early on empty FIFO with request pending
        cfg_len = 17'd5; cfg_start_rx = 1;
        step();
        cfg_start_rx = 0;
        check("rx5_words", 32'(words_left), 2);
        step(4);
        w_done_flag = 1;
        step();
        w_done_flag = 0;
        check("wdone_drain", 32'(state), 5);
        ahb_rd_req = 1; fifo_empty = 1;
        #1 check("rd_empty_nogrant", 32'(ahb_rd_grant), 0);
        step();
        ahb_rd_req = 0; fifo_empty = 0;
        check("empty_exit", 32'({state, done_irq, mode}), {3'd6, 1'b1, 1'b1});
        check("empty_words", 32'(words_left), 2);
        step(4);
        check("empty_idle", 32'(state), 0);

        // reset during RX_RUN
        cfg_len = 17'd20; cfg_start_rx = 1;
        step();
        cfg_start_rx = 0;
        step(4);
        check("pre_reset", 32'({state, ble_rx_en, mode}), {3'd4, 1'b1, 1'b0});
        reset = 1;
        step();
        reset = 0;
        check("mid_reset", 32'({state, mode, ble_rx_en, ble_tx_en, busy}), {3'd0, 1'b1, 3'b000});
        check("mid_reset_regs", 32'({data_size, words_left}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
